// File: rtl/fht_input_loader.sv
// fht_input_loader: scatters an N = 4*2^A_BIT sample frame into four FHT banks.
// Build option FHT_LOADER_BITREV_EN selects bit-reversed scatter (natural order otherwise).
module fht_input_loader #(
   parameter int A_BIT = 8,
   parameter int D_BIT = 16
) (
   input  logic             iCLK,
   input  logic             iRESET,
   input  logic             iVALID,
   input  logic [D_BIT-1:0] iDATA,
   output logic             oREADY,
   input  logic             iFHT_RDY,
   output logic             oSTART,
   output logic [3:0]       oWE,
   output logic [A_BIT-1:0] oADDR_WR,
   output logic [D_BIT-1:0] oDATA,
   output logic [A_BIT+1:0] oCNT,
   output logic             oBUSY
);

   localparam int C_BIT = A_BIT + 2;
   localparam logic [C_BIT-1:0] C_LAST = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_FLUSH,
      S_START,
      S_WAIT
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [C_BIT-1:0] r_cnt;
   logic [C_BIT-1:0] w_rev;
   logic [3:0]       w_bank_oh;
   logic [3:0]       r_we;
   logic [A_BIT-1:0] r_addr;
   logic [D_BIT-1:0] r_data;
   logic             w_acc;

   assign w_acc = (r_state == S_LOAD) && iVALID;

`ifdef FHT_LOADER_BITREV_EN
   // bank/address index is the sample number mirrored over all counter bits
   always_comb begin
      w_rev = '0;
      for (int i = 0; i < C_BIT; i++) begin
         w_rev[i] = r_cnt[C_BIT-1-i];
      end
   end
`else
   // source already delivers bit-reversed frames, scatter in natural order
   always_comb begin
      w_rev = r_cnt;
   end
`endif

   // top two index bits pick the bank, one-hot
   always_comb begin
      w_bank_oh = 4'b0001 << w_rev[C_BIT-1:C_BIT-2];
   end

   // state register
   always_ff @(posedge iCLK or posedge iRESET) begin
      if (iRESET) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // next state and state-decoded handshake/status outputs
   always_comb begin
      w_next = r_state;
      oREADY = 1'b0;
      oSTART = 1'b0;
      oBUSY  = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (iFHT_RDY) w_next = S_LOAD;
         end
         S_LOAD: begin
            oREADY = 1'b1;
            if (w_acc && (r_cnt == C_LAST)) w_next = S_FLUSH;
         end
         S_FLUSH: begin
            oBUSY  = 1'b1;
            w_next = S_START;
         end
         S_START: begin
            oBUSY  = 1'b1;
            oSTART = 1'b1;
            w_next = S_WAIT;
         end
         S_WAIT: begin
            oBUSY = 1'b1;
            if (iFHT_RDY) w_next = S_LOAD;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // sample counter and registered bank write port
   always_ff @(posedge iCLK or posedge iRESET) begin
      if (iRESET) begin
         r_cnt  <= '0;
         r_we   <= '0;
         r_addr <= '0;
         r_data <= '0;
      end else begin
         r_we <= '0;
         if (w_acc) begin
            r_cnt  <= r_cnt + C_BIT'(1);
            r_we   <= w_bank_oh;
            r_addr <= w_rev[A_BIT-1:0];
            r_data <= iDATA;
         end
      end
   end

   assign oWE      = r_we;
   assign oADDR_WR = r_addr;
   assign oDATA    = r_data;
   assign oCNT     = r_cnt;

endmodule

// File: tb/tb_fht_input_loader.sv
// tb_fht_input_loader: random-stimulus bench with a frame-level reference model.
// Mapping expectations follow FHT_LOADER_BITREV_EN the same way the design does.
module tb_fht_input_loader;

   localparam int A = 8;
   localparam int D = 16;
   localparam int N = 4 << A;
   localparam int M = 1 << A;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         vld = 1'b0;
   logic         rdy = 1'b0;
   logic [D-1:0] din = '0;
   logic         ready, start, busy;
   logic [3:0]   we;
   logic [A-1:0] addr;
   logic [D-1:0] dout;
   logic [A+1:0] cnt;

   int tests = 0;
   int fails = 0;

   fht_input_loader #(.A_BIT(A), .D_BIT(D)) dut (
      .iCLK(clk), .iRESET(rst), .iVALID(vld), .iDATA(din),
      .oREADY(ready), .iFHT_RDY(rdy), .oSTART(start), .oWE(we),
      .oADDR_WR(addr), .oDATA(dout), .oCNT(cnt), .oBUSY(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // sample index -> bank*M + addr
   function automatic int mapr(input int n);
      int r;
`ifdef FHT_LOADER_BITREV_EN
      r = 0;
      for (int i = 0; i < A + 2; i++) r |= ((n >> i) & 1) << (A + 1 - i);
`else
      r = n;
`endif
      return r;
   endfunction

   // reference model: phase 0 idle, 1 loading, 2 flush, 3 start, 4 waiting
   int         m_ph;
   int         m_cnt;
   logic [3:0] m_we;
   int         m_addr;
   int         m_data;

   always @(posedge clk or posedge rst) begin
      int r;
      if (rst) begin
         m_ph = 0; m_cnt = 0; m_we = 0; m_addr = 0; m_data = 0;
      end else begin
         m_we = 0;
         case (m_ph)
            0: if (rdy) m_ph = 1;
            1: if (vld) begin
               r      = mapr(m_cnt);
               m_we   = 4'(1 << (r / M));
               m_addr = r % M;
               m_data = int'(din);
               if (m_cnt == N - 1) begin
                  m_cnt = 0;
                  m_ph  = 2;
               end else begin
                  m_cnt++;
               end
            end
            2: m_ph = 3;
            3: m_ph = 4;
            default: if (rdy) m_ph = 1;
         endcase
      end
   end

   // per-cycle compare plus capture of bank writes
   int         starts = 0;
   int         readies = 0;
   int         hits = 0;
   logic [D-1:0] dmem [4][M];
   int         hitc [4][M];
   logic [3:0] lwe [$];
   int         la [$];
   int         ld [$];

   always begin
      int b;
      @(negedge clk);
      #2;
      chk("ready", ready, m_ph == 1);
      chk("start", start, m_ph == 3);
      chk("busy", busy, m_ph inside {2, 3, 4});
      chk("cnt", cnt, m_cnt);
      chk("we", we, m_we);
      chk("addr", addr, m_addr);
      chk("data", dout, m_data);
      if (start) starts++;
      if (ready) readies++;
      if (we != 0) begin
         chk("we_onehot", $onehot(we), 1);
         b = we[1] ? 1 : we[2] ? 2 : we[3] ? 3 : 0;
         dmem[b][addr] = dout;
         hitc[b][addr]++;
         hits++;
         lwe.push_back(we);
         la.push_back(int'(addr));
         ld.push_back(int'(dout));
      end
   end

   logic [D-1:0] src [N];

   task automatic clear_cap();
      hits = 0;
      lwe.delete(); la.delete(); ld.delete();
      for (int b = 0; b < 4; b++)
         for (int a = 0; a < M; a++) begin
            hitc[b][a] = 0;
            dmem[b][a] = '0;
         end
   endtask

   // drive samples at duty% until nacc have been accepted (bounded)
   task automatic send(input int duty, input bit seq, input int nacc);
      int idx = 0;
      int budget = 0;
      while (idx < nacc && budget < 20 * N) begin
         @(negedge clk);
         vld = ($urandom_range(99) < duty);
         din = seq ? D'(idx) : D'($urandom);
         src[idx] = din;
         if (vld && m_ph == 1) idx++;
         budget++;
      end
      chk("send_budget", idx, nacc);
   endtask

   initial begin
      int s0, r0, bad, r;
      // reset with live inputs
      rst = 1; vld = 1; rdy = 1; din = 16'hABCD;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_ready", ready, 0);
      chk("rst_start", start, 0);
      chk("rst_we", we, 0);
      chk("rst_addr", addr, 0);
      chk("rst_data", dout, 0);
      chk("rst_cnt", cnt, 0);
      chk("rst_busy", busy, 0);
      @(negedge clk);
      rst = 0; vld = 0;
      #1 chk("idle_ready", ready, 0);
      @(negedge clk);
      #1 chk("load_ready", ready, 1);
      rdy = 0;

      // frame 1: continuous, data = n
      clear_cap();
      s0 = starts;
      send(100, 1, N);
      @(negedge clk);
      vld = 0;
      #1;
      chk("flush_ready", ready, 0);
      chk("flush_busy", busy, 1);
      chk("flush_we", we, 4'b1000);
      chk("flush_addr", addr, 255);
      chk("flush_data", dout, 1023);
      @(negedge clk);
      #1 chk("start_pulse", start, 1);
      r0 = readies;
      repeat (2600) @(negedge clk);
      chk("wait_ready", readies - r0, 0);
      chk("wait_busy", busy, 1);
      chk("f1_starts", starts - s0, 1);
      chk("f1_writes", lwe.size(), N);
`ifdef FHT_LOADER_BITREV_EN
      chk("map0_we", lwe[0], 4'b0001); chk("map0_a", la[0], 0);
      chk("map1_we", lwe[1], 4'b0100); chk("map1_a", la[1], 0);
      chk("map2_we", lwe[2], 4'b0010); chk("map2_a", la[2], 0);
      chk("map3_we", lwe[3], 4'b1000); chk("map3_a", la[3], 0);
      chk("map4_we", lwe[4], 4'b0001); chk("map4_a", la[4], 128);
`else
      chk("map1_we", lwe[1], 4'b0001); chk("map1_a", la[1], 1);
      chk("map256_we", lwe[256], 4'b0010); chk("map256_a", la[256], 0);
`endif
      chk("map1023_we", lwe[1023], 4'b1000);
      chk("map1023_a", la[1023], 255);
      chk("map4_d", ld[4], 4);
      rdy = 1;
      @(negedge clk);
      #1;
      chk("resume_ready", ready, 1);
      chk("resume_cnt", cnt, 0);
      rdy = 0;

      // frame 2: gapped, random data
      clear_cap();
      s0 = starts;
      send(30, 0, N);
      @(negedge clk);
      vld = 0;
      repeat (5) @(negedge clk);
      chk("f2_starts", starts - s0, 1);
      chk("f2_writes", hits, N);
      bad = 0;
      for (int b = 0; b < 4; b++)
         for (int a = 0; a < M; a++)
            if (hitc[b][a] != 1) bad++;
      chk("f2_once", bad, 0);
      bad = 0;
      for (int n = 0; n < N; n++) begin
         r = mapr(n);
         if (dmem[r / M][r % M] !== src[n]) bad++;
      end
      chk("f2_data", bad, 0);
      rdy = 1;
      @(negedge clk);
      rdy = 0;

      // reset in the middle of a frame
      s0 = starts;
      send(100, 0, 500);
      @(negedge clk);
      rst = 1; vld = 0;
      #1;
      chk("mid_cnt", cnt, 0);
      chk("mid_we", we, 0);
      repeat (3) @(negedge clk);
      chk("mid_nostart", starts - s0, 0);
      rst = 0; rdy = 1;
      @(negedge clk);
      rdy = 0;
      clear_cap();
      send(60, 0, N);
      @(negedge clk);
      vld = 0;
      repeat (5) @(negedge clk);
      chk("f3_starts", starts - s0, 1);
      chk("f3_writes", hits, N);
      chk("f3_first_we", lwe[0], 4'b0001);
      chk("f3_first_a", la[0], 0);
      chk("f3_first_d", ld[0], int'(src[0]));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fht_input_loader.md
# fht_input_loader

Upstream neighbour of `fht_control`. Accepts a stream of N = 4·2^A_BIT real samples over a valid/ready handshake and scatters them into the four working RAM banks in bit-reversed order. When a full frame has been written and the control is idle, it pulses the start request. It then holds off new input until the transform reports ready again.

## Interface
- `A_BIT`, 8, bank address width; frame length N = 4·2^A_BIT (1024 at default).
- `D_BIT`, 16, sample width.

- `iCLK`  in  1  single clock, rising edge.
- `iRESET`  in  1  asynchronous, active-high reset.
- `iVALID`  in  1  input sample valid.
- `iDATA`  in  D_BIT  input sample.
- `oREADY`  out  1  loader accepts a sample this cycle.
- `iFHT_RDY`  in  1  ready flag from `fht_control`; high when the transform is idle.
- `oSTART`  out  1  one-cycle start pulse to `fht_control`.
- `oWE`  out  4  per-bank write enable; one-hot or zero.
- `oADDR_WR`  out  A_BIT  bank write address, shared by all banks.
- `oDATA`  out  D_BIT  bank write data, shared by all banks.
- `oCNT`  out  A_BIT+2  samples accepted in the current frame.
- `oBUSY`  out  1  high from frame complete until `iFHT_RDY` returns high.

## Operation
- State register states: IDLE, LOAD, FLUSH, START, WAIT.
- **IDLE** (reset state):
  - oREADY=0.
  - Go to LOAD when iFHT_RDY=1.
- **LOAD**:
  - oREADY=1. A sample is accepted on a rising edge with iVALID=1 & oREADY=1.
  - Each accept increments a sample counter n, width A_BIT+2.
  - On the accept of n = N−1: n wraps to 0 and the next state is FLUSH.
  - iVALID while oREADY=0 is ignored; no data is lost internally, and backpressure is the source's responsibility.
- **Address mapping** for sample n:
  - r = bit-reverse of n over A_BIT+2 bits.
  - bank = r[A_BIT+1:A_BIT].
  - addr = r[A_BIT−1:0].
- **FLUSH**:
  - One cycle; the last write is on the bus.
  - Next state START.
- **START**:
  - oSTART=1 for exactly this cycle.
  - Next state WAIT.
- **WAIT**:
  - oBUSY=1.
  - Go to LOAD on the first cycle with iFHT_RDY=1. `fht_control` drops its ready flag on the edge after start, so WAIT always sees it low first.
- oBUSY = 1 in FLUSH, START and WAIT; 0 otherwise.
- oCNT = n. It reads 0 in FLUSH, START, WAIT and IDLE.
- **Reset mid-frame**: async clear of state, counter and write outputs. The partial frame is discarded, and the next frame restarts at n=0 with no start pulse issued.

## Timing
- Reset values: oREADY=0, oSTART=0, oWE=0, oADDR_WR=0, oDATA=0, oCNT=0, oBUSY=0.
- oREADY is decoded from the state register only. It has no combinational path from iVALID or iFHT_RDY.
- Write latency is one cycle: an accept on edge k produces oWE/oADDR_WR/oDATA registered after edge k, valid for one cycle.
- Accepting every cycle gives back-to-back writes, one per cycle.
- The last write (n = N−1) is visible in FLUSH. oSTART follows one cycle later, so the last write has landed before start.
- Minimum frame time: N cycles of LOAD + FLUSH + START. WAIT then lasts the transform time.
- oWE bits that are not selected are 0. oADDR_WR/oDATA hold their last value when oWE=0.

## Configuration
- `FHT_LOADER_BITREV_EN`
- Defined: r = bit-reverse(n) as above. This is the default build; `fht_control` expects bit-reversed input.
- Undefined: r = n (natural order), so bank = n[A_BIT+1:A_BIT] and addr = n[A_BIT−1:0]. Used when the source already delivers bit-reversed frames.
- The FSM, handshake and timing are identical in both builds.

## Test plan
- **Reset defaults:** assert iRESET with iVALID=1 and iFHT_RDY=1 → all outputs 0. First cycle after release is in IDLE with oREADY=0. Next cycle is in LOAD with oREADY=1.
- **Mapping (BITREV_EN, A_BIT=8):** stream n=0..4, then 1023, with data = n. The required writes are:
  - n=0 → oWE=0001, addr 0.
  - n=1 → oWE=0100, addr 0.
  - n=2 → oWE=0010, addr 0.
  - n=3 → oWE=1000, addr 0.
  - n=4 → oWE=0001, addr 128.
  - n=1023 → oWE=1000, addr 255.
- **Mapping (macro undefined):** n=1 → oWE=0001, addr 1. n=256 → oWE=0010, addr 0. n=1023 → oWE=1000, addr 255.
- **Frame end:** 1024 consecutive accepts.
  - The cycle after the last accept shows oREADY=0, oBUSY=1 and the last write.
  - The following cycle shows a single oSTART=1.
  - Hold iFHT_RDY low for 2600 cycles → oREADY stays 0.
  - Raise iFHT_RDY → oREADY=1 next cycle, oCNT=0.
- **Gapped input:** toggle iVALID randomly at 30% duty → exactly 1024 writes, each address written once per bank, and the frame's data is preserved in order.
- **Reset mid-frame:** assert iRESET after 500 accepts → oCNT=0 and oSTART is never pulsed. A subsequent full frame starts at n=0 and produces exactly one oSTART.
